// File: rtl/sersub_pkg.sv
// rtl/sersub_pkg.sv - shared FSM state codes and width helper for serial_subtractor
package sersub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fs_bit.sv
// rtl/fs_bit.sv - combinational 1-bit full subtractor: d = x - y - bi
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle d = a - b - bin, DIGIT bits per clock
// Optional signed-overflow output ovf enabled by defining SERSUB_OVF_EN.
module serial_subtractor
    import sersub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (clog2(STEPS) > 0) ? clog2(STEPS) : 1;

    logic [1:0]             state_q;
    logic [WIDTH-1:0]       a_sh_q;
    logic [WIDTH-1:0]       b_sh_q;
    logic [WIDTH-1:0]       r_sh_q;
    logic                   brw_q;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       d_q;
    logic                   bo_q;

    logic [DIGIT:0]         chain;
    logic [DIGIT-1:0]       dig;
    logic [WIDTH+DIGIT-1:0] r_cat;
    logic [WIDTH-1:0]       r_d;
    logic                   accept;
    logic                   last;

    assign chain[0] = brw_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        fs_bit u_fs (
            .x  (a_sh_q[i]),
            .y  (b_sh_q[i]),
            .bi (chain[i]),
            .d  (dig[i]),
            .bo (chain[i+1])
        );
    end

    // New digit enters at the MSB end; after STEPS shifts the LSB digit sits at bit 0.
    assign r_cat  = {dig, r_sh_q};
    assign r_d    = r_cat[WIDTH+DIGIT-1:DIGIT];
    assign accept = start && (state_q != ST_RUN);
    assign last   = (state_q == ST_RUN) && (cnt_q == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bo_q    <= 1'b0;
        end else begin
            if (accept) begin
                a_sh_q  <= a;
                b_sh_q  <= b;
                brw_q   <= bin;
                cnt_q   <= '0;
                state_q <= ST_RUN;
            end else if (state_q == ST_RUN) begin
                a_sh_q <= a_sh_q >> DIGIT;
                b_sh_q <= b_sh_q >> DIGIT;
                r_sh_q <= r_d;
                brw_q  <= chain[DIGIT];
                cnt_q  <= cnt_q + CW'(1);
                if (last) begin
                    d_q     <= r_d;
                    bo_q    <= chain[DIGIT];
                    state_q <= ST_DONE;
                end
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

`ifdef SERSUB_OVF_EN
    logic [1:0] msb_q;
    logic       ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_q <= 2'b00;
            ovf_q <= 1'b0;
        end else begin
            if (accept) begin
                msb_q <= {a[WIDTH-1], b[WIDTH-1]};
            end
            if (last) begin
                ovf_q <= (msb_q[1] != msb_q[0]) && (r_d[WIDTH-1] != msb_q[1]);
            end
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign d    = d_q;
    assign bo   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (DIGIT=1 and DIGIT=4)
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start1 = 1'b0, bin1 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0;
    logic       busy1, done1, bo1;
    logic [7:0] d1;

    logic       start4 = 1'b0, bin4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bo4;
    logic [7:0] d4;

`ifdef SERSUB_OVF_EN
    logic       ovf1, ovf4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bo(bo1)
`ifdef SERSUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bo(bo4)
`ifdef SERSUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned 9-bit arithmetic gives borrow as bit 8.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int r;
        r = int'(x) - int'(y) - int'(bi);
        if (r < 0) r = r + 512;
        return 9'(r);
    endfunction

    // Counts busy cycles until done (bounded); called right after the accept edge's negedge.
    task automatic wait_done1(output int nbusy);
        int guard;
        nbusy = 0;
        guard = 0;
        while (!done1 && guard < 20) begin
            if (busy1) nbusy++;
            guard++;
            @(negedge clk);
        end
    endtask

    task automatic op1(input logic [7:0] x, input logic [7:0] y, input logic bi,
                       input logic [7:0] exp_d, input logic exp_bo, input string tag);
        int n;
        @(negedge clk);
        a1 = x; b1 = y; bin1 = bi; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        a1 = $urandom; b1 = $urandom; bin1 = 1'($urandom);
        wait_done1(n);
        chk({tag, "_busy_cycles"}, n, 8);
        chk({tag, "_done"}, done1, 1'b1);
        chk({tag, "_d"}, d1, exp_d);
        chk({tag, "_bo"}, bo1, exp_bo);
        chk({tag, "_model"}, {bo1, d1}, model(x, y, bi));
        @(negedge clk);
        chk({tag, "_done_pulse"}, done1, 1'b0);
    endtask

    initial begin
        int n;
        int dcount;
        logic [7:0] ra, rb;
        logic       rbi;
        logic [8:0] exp;

        #1;
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_d", d1, 8'h00);
        chk("rst_bo", bo1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        op1(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "sub_5_3");
        op1(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "sub_3_5");
        op1(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "sub_0_0_bin");

`ifdef SERSUB_OVF_EN
        op1(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "ovf_80_01");
        chk("ovf_80_01_ovf", ovf1, 1'b1);
        op1(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, "ovf_7f_01");
        chk("ovf_7f_01_ovf", ovf1, 1'b0);
`endif

        // start while busy must be ignored
        @(negedge clk);
        a1 = 8'h10; b1 = 8'h01; bin1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a1 = 8'hFF; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(n);
        chk("ignore_done", done1, 1'b1);
        chk("ignore_d", d1, 8'h0F);
        chk("ignore_bo", bo1, 1'b0);

        // reset in the middle of RUN
        @(negedge clk);
        a1 = 8'h10; b1 = 8'h01; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", busy1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy1, 1'b0);
        chk("midrst_d", d1, 8'h00);
        chk("midrst_bo", bo1, 1'b0);
        chk("midrst_done", done1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done1 || busy1) dcount++;
        end
        chk("midrst_no_done", dcount, 0);

        // DIGIT=4 random back-to-back operations
        ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
        @(negedge clk);
        a4 = ra; b4 = rb; bin4 = rbi; start4 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done4 && n < 10);
            exp = model(ra, rb, rbi);
            chk("d4_interval", n, 3);
            chk("d4_result", {bo4, d4}, exp);
`ifdef SERSUB_OVF_EN
            chk("d4_ovf", ovf4, (ra[7] != rb[7]) && (exp[7] != ra[7]));
`endif
            if (i == 999) begin
                start4 = 1'b0;
            end else begin
                ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
                a4 = ra; b4 = rb; bin4 = rbi;
            end
        end
        @(negedge clk);
        chk("d4_idle_busy", busy4, 1'b0);
        chk("d4_idle_done", done4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
